// File: rtl/i2s_slave_rx.sv
// ============================================================================
//  Module      : i2s_slave_rx
//  Description : Slave-mode I2S receiver. Oversamples SCK/WS/SD on
//                lmmi_clk_i, deserializes left/right words MSB-first and
//                presents one stereo frame through a valid/ready handshake.
//                Sticky flags report dropped frames and odd word lengths.
//                Define I2S_LJ_MODE_EN for left-justified framing (no 1-bit
//                WS delay); the default build uses standard I2S framing.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_slave_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  lmmi_clk_i,
    input  logic                  reset_i,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i,
    input  logic                  enable_i,
    output logic [DATA_WIDTH-1:0] sample_left_o,
    output logic [DATA_WIDTH-1:0] sample_right_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  overrun_o,
    output logic                  slot_err_o,
    input  logic                  clr_err_i
);

    localparam logic [5:0] c_SLOT_CNT = 6'(SLOT_WIDTH);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [2:0]            r_sck_sync;
    logic [1:0]            r_ws_sync;
    logic [1:0]            r_sd_sync;
    logic                  r_ws_prev;
    logic [5:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_ok;
    logic                  r_frame_stb;
    logic [DATA_WIDTH-1:0] r_frame_left;
    logic [DATA_WIDTH-1:0] r_frame_right;

    logic                  w_sck_rise;
    logic                  w_ws;
    logic                  w_sd;
    logic                  w_ws_chg;
    logic [5:0]            w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_shift_ins;
    logic [5:0]            w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_word_done;
    logic [DATA_WIDTH-1:0] w_word;
    logic [5:0]            w_word_cnt;
    logic                  w_enter_run;
    logic                  w_slot_evt;
    logic                  w_ovr_evt;
`ifdef I2S_LJ_MODE_EN
    logic [DATA_WIDTH-1:0] w_msb_word;
`endif

    // WS and SD are only needed at q2, which is aligned with the detected SCK rise
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_ws       = r_ws_sync[1];
    assign w_sd       = r_sd_sync[1];
    assign w_ws_chg   = w_ws ^ r_ws_prev;
    assign w_cnt_inc  = (r_bit_cnt == 6'd63) ? 6'd63 : r_bit_cnt + 6'd1;
    assign w_enter_run = (r_state == ST_SYNC) && (w_state_next == ST_RUN);
    assign w_slot_evt = w_word_done && (w_word_cnt != c_SLOT_CNT);
    assign w_ovr_evt  = r_frame_stb && sample_valid_o && !sample_ready_i;

    // Input synchronizers plus the SCK edge-detect delay flop
    always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], i2s_sck_i};
            r_ws_sync  <= {r_ws_sync[0], i2s_ws_i};
            r_sd_sync  <= {r_sd_sync[0], i2s_sd_i};
        end
    end

    // Drop the sampled bit into its MSB-first slot; bits beyond DATA_WIDTH never match
    always_comb begin
        w_shift_ins = r_shift;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_bit_cnt == 6'(DATA_WIDTH - 1 - i)) begin
                w_shift_ins[i] = w_sd;
            end
        end
`ifdef I2S_LJ_MODE_EN
        w_msb_word                 = '0;
        w_msb_word[DATA_WIDTH-1]   = w_sd;
`endif
    end

    // FSM state register
    always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, bit counter/shifter update and word-completion detection
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_word_done    = 1'b0;
        w_word         = r_shift;
        w_word_cnt     = r_bit_cnt;
        if (!enable_i) begin
            w_state_next = ST_SYNC;
        end else if (w_sck_rise) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_ws_chg) begin
                        w_state_next = ST_RUN;
`ifdef I2S_LJ_MODE_EN
                        // The edge bit is already the MSB of the new channel
                        w_bit_cnt_next = 6'd1;
                        w_shift_next   = w_msb_word;
`else
                        w_bit_cnt_next = 6'd0;
                        w_shift_next   = '0;
`endif
                    end
                end
                default: begin
                    if (w_ws_chg) begin
                        w_word_done = 1'b1;
`ifdef I2S_LJ_MODE_EN
                        // Word closes before the edge bit, which opens the next word
                        w_word         = r_shift;
                        w_word_cnt     = r_bit_cnt;
                        w_bit_cnt_next = 6'd1;
                        w_shift_next   = w_msb_word;
`else
                        // Edge bit is the LSB slot of the finishing word
                        w_word         = w_shift_ins;
                        w_word_cnt     = w_cnt_inc;
                        w_bit_cnt_next = 6'd0;
                        w_shift_next   = '0;
`endif
                    end else begin
                        w_bit_cnt_next = w_cnt_inc;
                        w_shift_next   = w_shift_ins;
                    end
                end
            endcase
        end
    end

    // Deserializer registers and WS history
    always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ws_prev <= 1'b0;
        end else begin
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            if (w_sck_rise) begin
                r_ws_prev <= w_ws;
            end
        end
    end

    // Pair a left word with the following right word into a frame strobe
    always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_left_hold   <= '0;
            r_left_ok     <= 1'b0;
            r_frame_stb   <= 1'b0;
            r_frame_left  <= '0;
            r_frame_right <= '0;
        end else begin
            r_frame_stb <= 1'b0;
            if (w_enter_run) begin
                r_left_ok <= 1'b0;
            end else if (w_word_done) begin
                if (!r_ws_prev) begin
                    r_left_hold <= w_word;
                    r_left_ok   <= 1'b1;
                end else if (r_left_ok) begin
                    r_frame_left  <= r_left_hold;
                    r_frame_right <= w_word;
                    r_frame_stb   <= 1'b1;
                    r_left_ok     <= 1'b0;
                end
            end
        end
    end

    // Output handshake and sticky error flags; a new event beats a clear
    always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
        if (reset_i) begin
            sample_left_o  <= '0;
            sample_right_o <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
            slot_err_o     <= 1'b0;
        end else begin
            if (r_frame_stb && (!sample_valid_o || sample_ready_i)) begin
                sample_left_o  <= r_frame_left;
                sample_right_o <= r_frame_right;
                sample_valid_o <= 1'b1;
            end else if (sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end
            overrun_o  <= (overrun_o  & ~clr_err_i) | w_ovr_evt;
            slot_err_o <= (slot_err_o & ~clr_err_i) | w_slot_evt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_slave_rx;

    localparam int DW        = 24;
    localparam int CLK_HALF  = 5;
    localparam int SCK_HALF  = 40;
    localparam int SCK_PER   = 2 * SCK_HALF;
`ifdef I2S_LJ_MODE_EN
    localparam bit LJ_BUILD = 1'b1;
`else
    localparam bit LJ_BUILD = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          sck   = 1'b0;
    logic          ws    = 1'b0;
    logic          sd    = 1'b0;
    logic          en    = 1'b1;
    logic          ready = 1'b1;
    logic          clr   = 1'b0;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic          valid;
    logic          overrun;
    logic          slot_err;

    int n_checks = 0;
    int n_errors = 0;

    logic          sd_q[$];
    logic          ch_q[$];
    logic [DW-1:0] cap_l[$];
    logic [DW-1:0] cap_r[$];

    typedef struct {
        bit          alt;     // 1: stream uses the framing opposite to the build
        logic [31:0] l_slot;
        logic [31:0] r_slot;
        int          nbits;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        logic        exp_serr;
    } vec_t;

    vec_t vecs[4];

    always #(CLK_HALF) clk = ~clk;

    i2s_slave_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(32)) dut (
        .lmmi_clk_i     (clk),
        .reset_i        (rst),
        .i2s_sck_i      (sck),
        .i2s_ws_i       (ws),
        .i2s_sd_i       (sd),
        .enable_i       (en),
        .sample_left_o  (left),
        .sample_right_o (right),
        .sample_valid_o (valid),
        .sample_ready_i (ready),
        .overrun_o      (overrun),
        .slot_err_o     (slot_err),
        .clr_err_i      (clr)
    );

    // Record every accepted frame
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            cap_l.push_back(left);
            cap_r.push_back(right);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic chn, input logic [31:0] v, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            sd_q.push_back(v[j]);
            ch_q.push_back(chn);
        end
    endtask

    // Master model: drives WS/SD on SCK fall; I2S leads WS by one bit
    task automatic play(input bit lj);
        int n;
        n = sd_q.size();
        for (int k = 0; k < n; k++) begin
            sd = sd_q[k];
            if (lj || (k + 1 >= n)) ws = ch_q[k];
            else                    ws = ch_q[k+1];
            sck = 1'b0;
            #(SCK_HALF);
            sck = 1'b1;
            #(SCK_HALF);
        end
        sck = 1'b0;
        sd_q.delete();
        ch_q.delete();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        cap_l.delete();
        cap_r.delete();
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h8000_0100, 32'h7FFF_FE00, 32, 24'h800001, 24'h7FFFFE, 1'b0};
        vecs[1] = '{1'b0, 32'h1234_5600, 32'h6543_2100, 32, 24'h123456, 24'h654321, 1'b0};
        vecs[2] = '{1'b0, 32'h000A_BCDE, 32'h0001_2345, 20, 24'hABCDE0, 24'h123450, 1'b1};
        if (LJ_BUILD)
            vecs[3] = '{1'b1, 32'h1234_5600, 32'h6543_2100, 32, 24'h091A2B, 24'h32A190, 1'b0};
        else
            vecs[3] = '{1'b1, 32'h1234_5600, 32'h6543_2100, 32, 24'h2468AC, 24'hCA8642, 1'b0};

        // Reset state
        wait_clks(3);
        check("rst_valid",   32'(valid),    32'd0);
        check("rst_left",    32'(left),     32'd0);
        check("rst_right",   32'(right),    32'd0);
        check("rst_overrun", 32'(overrun),  32'd0);
        check("rst_sloterr", 32'(slot_err), 32'd0);

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            do_reset();
            ready = 1'b1;
            push_bits(1'b0, 32'h0, 32);
            push_bits(1'b1, 32'h0, 32);
            push_bits(1'b0, vecs[v].l_slot, vecs[v].nbits);
            push_bits(1'b1, vecs[v].r_slot, vecs[v].nbits);
            push_bits(1'b0, 32'h0, 32);
            play(vecs[v].alt ^ LJ_BUILD);
            wait_clks(20);
            check($sformatf("v%0d_frames", v), cap_l.size(), 32'd1);
            if (cap_l.size() > 0) begin
                check($sformatf("v%0d_left", v),  32'(cap_l[0]), 32'(vecs[v].exp_l));
                check($sformatf("v%0d_right", v), 32'(cap_r[0]), 32'(vecs[v].exp_r));
            end
            check($sformatf("v%0d_sloterr", v), 32'(slot_err), 32'(vecs[v].exp_serr));
            check($sformatf("v%0d_overrun", v), 32'(overrun),  32'd0);
            if (vecs[v].exp_serr) begin
                clr = 1'b1;
                wait_clks(1);
                clr = 1'b0;
                wait_clks(1);
                check($sformatf("v%0d_serr_clr", v), 32'(slot_err), 32'd0);
            end
        end

        // Backpressure: three frames while not ready
        do_reset();
        ready = 1'b0;
        push_bits(1'b0, 32'h0, 32);
        push_bits(1'b1, 32'h0, 32);
        push_bits(1'b0, 32'h1111_1100, 32);
        push_bits(1'b1, 32'h2222_2200, 32);
        push_bits(1'b0, 32'h3333_3300, 32);
        push_bits(1'b1, 32'h4444_4400, 32);
        push_bits(1'b0, 32'h5555_5500, 32);
        push_bits(1'b1, 32'h6666_6600, 32);
        push_bits(1'b0, 32'h0, 32);
        play(LJ_BUILD);
        wait_clks(20);
        check("bp_valid",   32'(valid),   32'd1);
        check("bp_left",    32'(left),    32'h111111);
        check("bp_right",   32'(right),   32'h222222);
        check("bp_overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        wait_clks(1);
        ready = 1'b0;
        wait_clks(1);
        check("bp_valid_drop", 32'(valid), 32'd0);
        check("bp_ovr_hold",   32'(overrun), 32'd1);
        clr = 1'b1;
        wait_clks(1);
        clr = 1'b0;
        wait_clks(1);
        check("bp_ovr_clr",  32'(overrun),  32'd0);
        check("bp_sloterr",  32'(slot_err), 32'd0);

        // Reset released during bit 10 of a left word
        rst = 1'b1;
        ready = 1'b1;
        wait_clks(2);
        cap_l.delete();
        cap_r.delete();
        push_bits(1'b0, 32'hFFFF_FF00, 32);
        push_bits(1'b1, 32'hAAAA_AA00, 32);
        push_bits(1'b0, 32'h0F0F_0F00, 32);
        push_bits(1'b1, 32'hF0F0_F000, 32);
        push_bits(1'b0, 32'h0, 32);
        fork
            play(LJ_BUILD);
            begin
                #(10 * SCK_PER + SCK_HALF / 2);
                rst = 1'b0;
            end
        join
        wait_clks(20);
        check("mid_frames", cap_l.size(), 32'd1);
        if (cap_l.size() > 0) begin
            check("mid_left",  32'(cap_l[0]), 32'h0F0F0F);
            check("mid_right", 32'(cap_r[0]), 32'hF0F0F0);
        end
        check("mid_sloterr", 32'(slot_err), 32'd0);

        // Asynchronous reset in the middle of a right word
        do_reset();
        ready = 1'b0;
        push_bits(1'b0, 32'h0, 32);
        push_bits(1'b1, 32'h0, 32);
        push_bits(1'b0, 32'h0A0A_0A00, 32);
        push_bits(1'b1, 32'h0B0B_0B00, 32);
        push_bits(1'b0, 32'h0C0C_0C00, 32);
        push_bits(1'b1, 32'h0D0D_0D00, 32);
        push_bits(1'b0, 32'h1020_3000, 32);
        push_bits(1'b1, 32'h4050_6000, 32);
        push_bits(1'b0, 32'h7080_9000, 32);
        push_bits(1'b1, 32'hA0B0_C000, 32);
        push_bits(1'b0, 32'h0, 32);
        fork
            play(LJ_BUILD);
            begin
                #(170 * SCK_PER + SCK_HALF / 2);
                check("ar_pre_valid", 32'(valid), 32'd1);
                check("ar_pre_left",  32'(left),  32'h0A0A0A);
                rst = 1'b1;
                #1;
                check("ar_valid", 32'(valid), 32'd0);
                check("ar_left",  32'(left),  32'd0);
                check("ar_right", 32'(right), 32'd0);
                #(3 * SCK_PER - 1);
                rst = 1'b0;
                ready = 1'b1;
            end
        join
        wait_clks(20);
        check("ar_frames", cap_l.size(), 32'd2);
        if (cap_l.size() >= 2) begin
            check("ar_f0_left",  32'(cap_l[0]), 32'h102030);
            check("ar_f0_right", 32'(cap_r[0]), 32'h405060);
            check("ar_f1_left",  32'(cap_l[1]), 32'h708090);
            check("ar_f1_right", 32'(cap_r[1]), 32'hA0B0C0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
